// File: rtl/mem_bus_arbiter_32_pkg.sv
// Shared definitions for the two-port memory bus arbiter.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } state_t;

  // Default watchdog limit and the counter width that can hold it.
  localparam int TIMEOUT_DEFAULT = 64;
  localparam int CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/mem_bus_arbiter_32_if.sv
// Bus bundle between the two requesters, the arbiter and the memory decoder.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_bus_arbiter_32_if;

  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read, mem_write;
  logic        mem_ready;
  logic        grant_id;
  logic        busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    output rdata0, rdata1, ack0, ack1, err0, err1, mem_addr, mem_wdata,
           mem_read, mem_write, grant_id, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    input  rdata0, rdata1, ack0, ack1, err0, err1, mem_addr, mem_wdata,
           mem_read, mem_write, grant_id, busy
  );

endinterface

// File: rtl/mem_bus_arbiter_32_rr_arbiter_2.sv
// Two-way round-robin winner select: a lone requester wins outright,
// under contention the port that was not served last wins.
module rr_arbiter_2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  // Pure combinational pick; the caller decides when to use it.
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) winner = ~last_grant;
    else if (req1)    winner = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter_32.sv
// Shares one 32-bit memory port between the CPU (port 0) and DMA (port 1).
// One transaction at a time: IDLE -> ACCESS -> RESP, with a watchdog that
// aborts an access whose mem_ready never arrives.
module mem_bus_arbiter_32
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_bus_arbiter_32_if.slave bus
);

  state_t      state, state_next;
  logic        any_req, winner;
  logic        grant, last_grant;
  logic        we_l, err_l;
  logic [CNT_W-1:0] cnt;
  logic [31:0] addr_l, wdata_l;
  logic [31:0] rdata0_r, rdata1_r;
  logic        timeout_hit;

  rr_arbiter_2 u_rr (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // State register; reset drops straight back to IDLE so strobes fall at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state: a ready response beats a watchdog expiry in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (any_req) state_next = S_ACCESS;
      S_ACCESS: if (bus.mem_ready || timeout_hit) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: latch the winner's request at grant, count wait states,
  // capture read data or zero it on abort, remember who was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      we_l       <= 1'b0;
      err_l      <= 1'b0;
      cnt        <= '0;
      addr_l     <= '0;
      wdata_l    <= '0;
      rdata0_r   <= '0;
      rdata1_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant   <= winner;
            addr_l  <= winner ? bus.addr1  : bus.addr0;
            wdata_l <= winner ? bus.wdata1 : bus.wdata0;
            we_l    <= winner ? bus.we1    : bus.we0;
            cnt     <= '0;
            err_l   <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (bus.mem_ready) begin
            if (!we_l) begin
              if (grant) rdata1_r <= bus.mem_rdata;
              else       rdata0_r <= bus.mem_rdata;
            end
            last_grant <= grant;
            err_l      <= 1'b0;
          end else if (timeout_hit) begin
            if (grant) rdata1_r <= '0;
            else       rdata0_r <= '0;
            last_grant <= grant;
            err_l      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and handshakes decode directly from the state register.
  always_comb begin
    bus.mem_read  = (state == S_ACCESS) && !we_l;
    bus.mem_write = (state == S_ACCESS) &&  we_l;
    bus.busy      = (state != S_IDLE);
    bus.ack0      = (state == S_RESP) && !grant;
    bus.ack1      = (state == S_RESP) &&  grant;
    bus.err0      = (state == S_RESP) && !grant && err_l;
    bus.err1      = (state == S_RESP) &&  grant && err_l;
    bus.grant_id  = grant;
    bus.mem_addr  = addr_l;
    bus.mem_wdata = wdata_l;
    bus.rdata0    = rdata0_r;
    bus.rdata1    = rdata1_r;
  end

endmodule
